// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// occupancy output, FWFT or registered read, write-through when full, flush and sticky errors.
module sync_fifo_flags #(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter bit FWFT          = 1'b1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  flush,
  input  logic                                  clr_err,
  input  logic                                  wr_en,
  input  logic [DATA_WIDTH-1:0]                 wr_data,
  output logic                                  full,
  output logic                                  almost_full,
  input  logic                                  rd_en,
  output logic [DATA_WIDTH-1:0]                 rd_data,
  output logic                                  rd_valid,
  output logic                                  empty,
  output logic                                  almost_empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]       level,
  output logic                                  overflow,
  output logic                                  underflow
);

  localparam int ADDR_WIDTH  = $clog2(FIFO_DEPTH);
  localparam int LEVEL_WIDTH = $clog2(FIFO_DEPTH + 1);

  localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR   = ADDR_WIDTH'(FIFO_DEPTH - 1);
  localparam logic [LEVEL_WIDTH-1:0] DEPTH_LEVEL = LEVEL_WIDTH'(FIFO_DEPTH);
  localparam logic [LEVEL_WIDTH-1:0] AFULL_LEVEL = LEVEL_WIDTH'(AFULL_THRESH);
  localparam logic [LEVEL_WIDTH-1:0] AEMPTY_LEVEL = LEVEL_WIDTH'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];

  logic [ADDR_WIDTH-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [ADDR_WIDTH-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [LEVEL_WIDTH-1:0] level_reg, level_next;
  logic                   overflow_reg, overflow_next;
  logic                   underflow_reg, underflow_next;

  logic full_int;
  logic empty_int;
  logic rd_acc;
  logic wr_acc;
  logic ovf_set;
  logic unf_set;

  // All status is decoded from the registered level only, never from wr_en/rd_en.
  assign full_int  = (level_reg == DEPTH_LEVEL);
  assign empty_int = (level_reg == '0);

  assign full         = full_int;
  assign empty        = empty_int;
  assign almost_full  = (level_reg >= AFULL_LEVEL);
  assign almost_empty = (level_reg <= AEMPTY_LEVEL);
  assign level        = level_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

  // A read frees a slot in the same cycle, so a full FIFO can still take a write.
  assign rd_acc  = rd_en && !empty_int && !flush;
  assign wr_acc  = wr_en && !flush && (!full_int || rd_acc);
  assign ovf_set = wr_en && !wr_acc && !flush;
  assign unf_set = rd_en && empty_int && !flush;

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    level_next     = level_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;

    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      level_next  = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_next = (wr_ptr_reg == LAST_ADDR) ? '0 : wr_ptr_reg + ADDR_WIDTH'(1);
      end
      if (rd_acc) begin
        rd_ptr_next = (rd_ptr_reg == LAST_ADDR) ? '0 : rd_ptr_reg + ADDR_WIDTH'(1);
      end
      if (wr_acc && !rd_acc) begin
        level_next = level_reg + LEVEL_WIDTH'(1);
      end else if (rd_acc && !wr_acc) begin
        level_next = level_reg - LEVEL_WIDTH'(1);
      end
    end

    // Set has priority over clear so no error event is lost.
    if (ovf_set) begin
      overflow_next = 1'b1;
    end else if (clr_err) begin
      overflow_next = 1'b0;
    end
    if (unf_set) begin
      underflow_next = 1'b1;
    end else if (clr_err) begin
      underflow_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      level_reg     <= level_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // Storage carries no reset so it can map onto RAM resources.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign rd_data  = mem[rd_ptr_reg];
      assign rd_valid = !empty_int;
    end else begin : g_reg_read
      logic [DATA_WIDTH-1:0] rd_data_reg;
      logic                  rd_valid_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data_reg  <= '0;
          rd_valid_reg <= 1'b0;
        end else begin
          rd_valid_reg <= rd_acc;
          if (rd_acc) begin
            rd_data_reg <= mem[rd_ptr_reg];
          end
        end
      end

      assign rd_data  = rd_data_reg;
      assign rd_valid = rd_valid_reg;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: DEPTH=16 FWFT, DEPTH=5 FWFT wrap, DEPTH=16 registered read.
module tb_sync_fifo_flags;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int errors = 0;
  int checks = 0;

  // Instance a: DEPTH=16, AFULL=14, AEMPTY=2, FWFT=1
  logic a_flush, a_clr, a_wr, a_rd;
  logic [7:0] a_wdata, a_rdata;
  logic a_full, a_af, a_rv, a_empty, a_ae, a_ov, a_uf;
  logic [4:0] a_level;

  // Instance b: DEPTH=5, AFULL=4, AEMPTY=1, FWFT=1
  logic b_flush, b_clr, b_wr, b_rd;
  logic [7:0] b_wdata, b_rdata;
  logic b_full, b_af, b_rv, b_empty, b_ae, b_ov, b_uf;
  logic [2:0] b_level;

  // Instance c: DEPTH=16, AFULL=14, AEMPTY=2, FWFT=0
  logic c_flush, c_clr, c_wr, c_rd;
  logic [7:0] c_wdata, c_rdata;
  logic c_full, c_af, c_rv, c_empty, c_ae, c_ov, c_uf;
  logic [4:0] c_level;

  sync_fifo_flags #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .AFULL_THRESH(14), .AEMPTY_THRESH(2), .FWFT(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush), .clr_err(a_clr), .wr_en(a_wr), .wr_data(a_wdata),
    .full(a_full), .almost_full(a_af), .rd_en(a_rd), .rd_data(a_rdata), .rd_valid(a_rv),
    .empty(a_empty), .almost_empty(a_ae), .level(a_level), .overflow(a_ov), .underflow(a_uf));

  sync_fifo_flags #(.DATA_WIDTH(8), .FIFO_DEPTH(5), .AFULL_THRESH(4), .AEMPTY_THRESH(1), .FWFT(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .clr_err(b_clr), .wr_en(b_wr), .wr_data(b_wdata),
    .full(b_full), .almost_full(b_af), .rd_en(b_rd), .rd_data(b_rdata), .rd_valid(b_rv),
    .empty(b_empty), .almost_empty(b_ae), .level(b_level), .overflow(b_ov), .underflow(b_uf));

  sync_fifo_flags #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .AFULL_THRESH(14), .AEMPTY_THRESH(2), .FWFT(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(c_flush), .clr_err(c_clr), .wr_en(c_wr), .wr_data(c_wdata),
    .full(c_full), .almost_full(c_af), .rd_en(c_rd), .rd_data(c_rdata), .rd_valid(c_rv),
    .empty(c_empty), .almost_empty(c_ae), .level(c_level), .overflow(c_ov), .underflow(c_uf));

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    {a_flush, a_clr, a_wr, a_rd} = '0; a_wdata = '0;
    {b_flush, b_clr, b_wr, b_rd} = '0; b_wdata = '0;
    {c_flush, c_clr, c_wr, c_rd} = '0; c_wdata = '0;
    #12;
    checks++; if (a_level !== 5'd0) begin errors++; $display("FAIL reset_level actual=%0d required=0", a_level); end
    checks++; if ({a_empty, a_full, a_ae, a_af} !== 4'b1010) begin errors++; $display("FAIL reset_flags actual=%b required=1010", {a_empty, a_full, a_ae, a_af}); end
    checks++; if ({a_ov, a_uf, a_rv} !== 3'b000) begin errors++; $display("FAIL reset_err actual=%b required=000", {a_ov, a_uf, a_rv}); end
    checks++; if ({c_rdata, c_rv} !== 9'h000) begin errors++; $display("FAIL reset_regread actual=%h/%b required=00/0", c_rdata, c_rv); end
    checks++; if ({b_level, b_empty} !== 4'b0001) begin errors++; $display("FAIL reset_b actual=%0d/%b required=0/1", b_level, b_empty); end
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    $display("reset released");
  endtask

  task automatic test_fill;
    for (int i = 0; i < 16; i++) begin
      a_wr = 1'b1; a_wdata = 8'(i);
      tick;
      a_wr = 1'b0;
      $display("wr a data=%02h level=%0d", i, a_level);
      checks++; if (a_level !== 5'(i + 1)) begin errors++; $display("FAIL fill_level actual=%0d required=%0d", a_level, i + 1); end
      checks++; if (a_ae !== ((i + 1) <= 2)) begin errors++; $display("FAIL fill_aempty n=%0d actual=%b", i + 1, a_ae); end
      checks++; if (a_af !== ((i + 1) >= 14)) begin errors++; $display("FAIL fill_afull n=%0d actual=%b", i + 1, a_af); end
      checks++; if (a_full !== ((i + 1) == 16)) begin errors++; $display("FAIL fill_full n=%0d actual=%b", i + 1, a_full); end
      checks++; if ({a_rdata, a_rv, a_empty} !== {8'h00, 2'b10}) begin errors++; $display("FAIL fill_head actual=%h/%b/%b required=00/1/0", a_rdata, a_rv, a_empty); end
    end
  endtask

  task automatic test_overflow;
    a_wr = 1'b1; a_wdata = 8'h99;
    tick;
    a_wr = 1'b0;
    $display("wr a data=99 while full");
    checks++; if ({a_ov, a_uf} !== 2'b10) begin errors++; $display("FAIL ovf_flag actual=%b required=10", {a_ov, a_uf}); end
    checks++; if (a_level !== 5'd16) begin errors++; $display("FAIL ovf_level actual=%0d required=16", a_level); end
    tick;
    checks++; if (a_ov !== 1'b1) begin errors++; $display("FAIL ovf_sticky actual=%b required=1", a_ov); end
    a_clr = 1'b1;
    tick;
    a_clr = 1'b0;
    checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL ovf_clear actual=%b required=0", a_ov); end
  endtask

  task automatic test_full_rw;
    a_rd = 1'b1; a_wr = 1'b1; a_wdata = 8'hAA;
    tick;
    {a_rd, a_wr} = 2'b00;
    $display("rd+wr a data=AA while full");
    checks++; if (a_level !== 5'd16) begin errors++; $display("FAIL fullrw_level actual=%0d required=16", a_level); end
    checks++; if ({a_ov, a_uf, a_full} !== 3'b001) begin errors++; $display("FAIL fullrw_flags actual=%b required=001", {a_ov, a_uf, a_full}); end
  endtask

  task automatic test_drain;
    logic [7:0] exp;
    for (int i = 0; i < 16; i++) begin
      exp = (i < 15) ? 8'(i + 1) : 8'hAA;
      checks++; if (a_rdata !== exp) begin errors++; $display("FAIL drain_data idx=%0d actual=%h required=%h", i, a_rdata, exp); end
      a_rd = 1'b1;
      tick;
      a_rd = 1'b0;
      $display("rd a data=%02h level=%0d", exp, a_level);
      checks++; if (a_level !== 5'(15 - i)) begin errors++; $display("FAIL drain_level actual=%0d required=%0d", a_level, 15 - i); end
    end
    checks++; if ({a_empty, a_ae, a_rv, a_ov, a_uf} !== 5'b11000) begin errors++; $display("FAIL drain_end actual=%b required=11000", {a_empty, a_ae, a_rv, a_ov, a_uf}); end
  endtask

  task automatic test_underflow;
    a_rd = 1'b1;
    tick;
    a_rd = 1'b0;
    checks++; if ({a_uf, a_ov, a_level} !== {2'b10, 5'd0}) begin errors++; $display("FAIL unf_flag actual=%b/%b/%0d required=1/0/0", a_uf, a_ov, a_level); end
    a_clr = 1'b1;
    tick;
    a_clr = 1'b0;
    checks++; if (a_uf !== 1'b0) begin errors++; $display("FAIL unf_clear actual=%b required=0", a_uf); end
    // set and clear together: set must win
    a_rd = 1'b1; a_clr = 1'b1;
    tick;
    {a_rd, a_clr} = 2'b00;
    checks++; if (a_uf !== 1'b1) begin errors++; $display("FAIL unf_setwins actual=%b required=1", a_uf); end
    a_clr = 1'b1;
    tick;
    a_clr = 1'b0;
    // write and read on empty: read rejected, no bypass
    a_rd = 1'b1; a_wr = 1'b1; a_wdata = 8'h5A;
    tick;
    {a_rd, a_wr} = 2'b00;
    checks++; if ({a_uf, a_level, a_rdata} !== {1'b1, 5'd1, 8'h5A}) begin errors++; $display("FAIL empty_rw actual=%b/%0d/%h required=1/1/5a", a_uf, a_level, a_rdata); end
    // accepted read with clr: nothing sets, clear applies
    a_rd = 1'b1; a_clr = 1'b1;
    tick;
    {a_rd, a_clr} = 2'b00;
    checks++; if ({a_uf, a_level, a_empty} !== {1'b0, 5'd0, 1'b1}) begin errors++; $display("FAIL read_clr actual=%b/%0d/%b required=0/0/1", a_uf, a_level, a_empty); end
  endtask

  task automatic test_flush;
    for (int i = 0; i < 7; i++) begin
      a_wr = 1'b1; a_wdata = 8'(8'h70 + i);
      tick;
    end
    a_wr = 1'b0;
    checks++; if (a_level !== 5'd7) begin errors++; $display("FAIL flush_pre actual=%0d required=7", a_level); end
    a_flush = 1'b1; a_wr = 1'b1; a_rd = 1'b1; a_wdata = 8'hEE;
    tick;
    {a_flush, a_wr, a_rd} = 3'b000;
    $display("flush a at level 7");
    checks++; if ({a_level, a_empty} !== {5'd0, 1'b1}) begin errors++; $display("FAIL flush_level actual=%0d/%b required=0/1", a_level, a_empty); end
    checks++; if ({a_ov, a_uf} !== 2'b00) begin errors++; $display("FAIL flush_err actual=%b required=00", {a_ov, a_uf}); end
    tick;
    checks++; if ({a_level, a_empty} !== {5'd0, 1'b1}) begin errors++; $display("FAIL flush_nowrite actual=%0d/%b required=0/1", a_level, a_empty); end
    a_wr = 1'b1; a_wdata = 8'h01;
    tick;
    a_wr = 1'b0;
    checks++; if (a_rdata !== 8'h01) begin errors++; $display("FAIL flush_head actual=%h required=01", a_rdata); end
    a_rd = 1'b1;
    tick;
    a_rd = 1'b0;
  endtask

  task automatic test_wrap;
    logic [2:0] exp_lvl;
    logic [7:0] exp;
    for (int i = 0; i < 12; i++) begin
      b_wr = 1'b1; b_wdata = 8'(8'h30 + i);
      b_rd = (i >= 5);
      if (i >= 5) begin
        exp = 8'(8'h30 + i - 5);
        checks++; if (b_rdata !== exp) begin errors++; $display("FAIL wrap_data idx=%0d actual=%h required=%h", i, b_rdata, exp); end
      end
      tick;
      {b_wr, b_rd} = 2'b00;
      exp_lvl = (i < 5) ? 3'(i + 1) : 3'd5;
      $display("wr b data=%02h level=%0d", 8'h30 + i, b_level);
      checks++; if (b_level !== exp_lvl) begin errors++; $display("FAIL wrap_level actual=%0d required=%0d", b_level, exp_lvl); end
      checks++; if ({b_full, b_af, b_ov} !== {exp_lvl == 3'd5, exp_lvl >= 3'd4, 1'b0}) begin errors++; $display("FAIL wrap_flags actual=%b lvl=%0d", {b_full, b_af, b_ov}, exp_lvl); end
    end
    for (int k = 0; k < 5; k++) begin
      exp = 8'(8'h37 + k);
      checks++; if (b_rdata !== exp) begin errors++; $display("FAIL wrap_drain actual=%h required=%h", b_rdata, exp); end
      b_rd = 1'b1;
      tick;
      b_rd = 1'b0;
      $display("rd b data=%02h level=%0d", exp, b_level);
    end
    checks++; if ({b_empty, b_level, b_uf} !== {1'b1, 3'd0, 1'b0}) begin errors++; $display("FAIL wrap_end actual=%b/%0d/%b required=1/0/0", b_empty, b_level, b_uf); end
  endtask

  task automatic test_regread;
    c_wr = 1'b1; c_wdata = 8'h11;
    tick;
    c_wdata = 8'h22;
    tick;
    c_wr = 1'b0;
    checks++; if ({c_rv, c_level} !== {1'b0, 5'd2}) begin errors++; $display("FAIL rr_pre actual=%b/%0d required=0/2", c_rv, c_level); end
    c_rd = 1'b1;
    tick;
    checks++; if ({c_rv, c_rdata} !== {1'b1, 8'h11}) begin errors++; $display("FAIL rr_first actual=%b/%h required=1/11", c_rv, c_rdata); end
    tick;
    c_rd = 1'b0;
    checks++; if ({c_rv, c_rdata} !== {1'b1, 8'h22}) begin errors++; $display("FAIL rr_second actual=%b/%h required=1/22", c_rv, c_rdata); end
    tick;
    $display("rd c data=%02h valid=%b", c_rdata, c_rv);
    checks++; if ({c_rv, c_rdata, c_empty, c_uf} !== {1'b0, 8'h22, 2'b10}) begin errors++; $display("FAIL rr_hold actual=%b/%h/%b/%b required=0/22/1/0", c_rv, c_rdata, c_empty, c_uf); end
  endtask

  task automatic test_back_to_back;
    c_wr = 1'b1; c_wdata = 8'h40;
    tick;
    for (int k = 1; k <= 4; k++) begin
      c_wr = 1'b1; c_rd = 1'b1; c_wdata = 8'(8'h40 + k);
      tick;
      $display("rd+wr c data=%02h", c_rdata);
      checks++; if ({c_rv, c_rdata, c_level} !== {1'b1, 8'(8'h40 + k - 1), 5'd1}) begin errors++; $display("FAIL b2b actual=%b/%h/%0d required=1/%h/1", c_rv, c_rdata, c_level, 8'h40 + k - 1); end
    end
    c_wr = 1'b0;
    tick;
    c_rd = 1'b0;
    checks++; if ({c_rv, c_rdata, c_empty} !== {1'b1, 8'h44, 1'b1}) begin errors++; $display("FAIL b2b_last actual=%b/%h/%b required=1/44/1", c_rv, c_rdata, c_empty); end
  endtask

  task automatic test_flush_regread;
    c_wr = 1'b1; c_wdata = 8'h55;
    tick;
    c_wdata = 8'h66;
    tick;
    c_wr = 1'b0; c_rd = 1'b1;
    tick;
    c_rd = 1'b0;
    checks++; if ({c_rv, c_rdata} !== {1'b1, 8'h55}) begin errors++; $display("FAIL rrflush_pre actual=%b/%h required=1/55", c_rv, c_rdata); end
    c_flush = 1'b1; c_rd = 1'b1;
    tick;
    {c_flush, c_rd} = 2'b00;
    $display("flush c with rd_en");
    checks++; if ({c_rv, c_rdata, c_level, c_uf} !== {1'b0, 8'h55, 5'd0, 1'b0}) begin errors++; $display("FAIL rrflush actual=%b/%h/%0d/%b required=0/55/0/0", c_rv, c_rdata, c_level, c_uf); end
  endtask

  task automatic test_reset_midstream;
    for (int i = 0; i < 3; i++) begin
      a_wr = 1'b1; a_wdata = 8'(8'hC0 + i);
      tick;
    end
    a_wr = 1'b0;
    checks++; if (a_level !== 5'd3) begin errors++; $display("FAIL rst_pre actual=%0d required=3", a_level); end
    rst_n = 1'b0;
    #2;
    $display("async reset at level 3");
    checks++; if ({a_level, a_empty, a_ae} !== {5'd0, 2'b11}) begin errors++; $display("FAIL rst_mid actual=%0d/%b/%b required=0/1/1", a_level, a_empty, a_ae); end
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    checks++; if ({a_level, a_empty} !== {5'd0, 1'b1}) begin errors++; $display("FAIL rst_after actual=%0d/%b required=0/1", a_level, a_empty); end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_overflow;
    test_full_rw;
    test_drain;
    test_underflow;
    test_flush;
    test_wrap;
    test_regread;
    test_back_to_back;
    test_flush_regread;
    test_reset_midstream;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
